// File: rtl/sprite_ram_dbuf.sv
// sprite_ram_dbuf: double-buffered 64 x 32-bit sprite attribute RAM.
// The evaluator reads the display bank; the CPU writes the back bank.
// The banks swap on a frame boundary. After each swap a copy pass brings the
// back bank up to date, and a clear pass can hide every sprite in the back bank.
// Optional CPU readback port of the back bank: define SPRITE_RAM_READBACK_EN.
module sprite_ram_dbuf #(
  parameter int          SPRITE_NUM = 64,
  parameter logic [31:0] CLEAR_WORD = 32'h00FF0000,
  localparam int         AW         = $clog2(SPRITE_NUM)
) (
  input  logic          clkEightRam,
  input  logic          rstn,
  input  logic [AW-1:0] addrReadEightRam,
  output logic [31:0]   dataToEightRam,
  input  logic          frameStart,
  input  logic          cpuWrEn,
  input  logic [AW-1:0] cpuWrAddr,
  input  logic [31:0]   cpuWrData,
  input  logic          cpuSwapReq,
  input  logic          cpuClearReq,
`ifdef SPRITE_RAM_READBACK_EN
  input  logic          cpuRdEn,
  input  logic [AW-1:0] cpuRdAddr,
  output logic [31:0]   cpuRdData,
`endif
  output logic          cpuBusy,
  output logic          wrDropErr,
  output logic          displayBank
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COPY
  } state_e;

  localparam logic [AW-1:0] CNT_LAST = AW'(SPRITE_NUM - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          displayBank_q;
  logic          swapPend_q;
  logic          wrDropErr_q;
  logic [31:0]   dataRd_q;
  logic [31:0]   mem_q [2][SPRITE_NUM];

  logic          backBank;
  logic          swapNow;
  logic [31:0]   copyData;
  logic          memWrEn_d;
  logic [AW-1:0] memWrAddr_d;
  logic [31:0]   memWrData_d;

  assign backBank = ~displayBank_q;
  assign copyData = mem_q[displayBank_q][cnt_q];
  assign swapNow  = (state_q == ST_IDLE) && frameStart && swapPend_q;

  // Select the single back-bank write for this cycle: CPU in IDLE, else the running pass
  always_comb begin
    memWrEn_d   = 1'b0;
    memWrAddr_d = cnt_q;
    memWrData_d = CLEAR_WORD;
    case (state_q)
      ST_IDLE: begin
        if (cpuWrEn) begin
          memWrEn_d   = 1'b1;
          memWrAddr_d = cpuWrAddr;
          memWrData_d = cpuWrData;
        end
      end
      ST_CLEAR: begin
        memWrEn_d = 1'b1;
      end
      ST_COPY: begin
        memWrEn_d   = 1'b1;
        memWrData_d = copyData;
      end
      default: begin
        memWrEn_d = 1'b0;
      end
    endcase
  end

  // Both banks reload the hidden-sprite word on reset; otherwise take the back-bank write
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SPRITE_NUM; i++) begin
          mem_q[b][i] <= CLEAR_WORD;
        end
      end
    end else if (memWrEn_d) begin
      mem_q[backBank][memWrAddr_d] <= memWrData_d;
    end
  end

  // Evaluator read port: one cycle latency from the bank displayed in this cycle
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      dataRd_q <= '0;
    end else begin
      dataRd_q <= mem_q[displayBank_q][addrReadEightRam];
    end
  end

  // Control FSM: swap arbitration, clear/copy sequencing and the sticky drop flag
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      displayBank_q <= 1'b0;
      swapPend_q    <= 1'b0;
      wrDropErr_q   <= 1'b0;
    end else begin
      if (cpuSwapReq) begin
        swapPend_q <= 1'b1;
      end else if (swapNow) begin
        swapPend_q <= 1'b0;
      end

      if (cpuWrEn && (state_q != ST_IDLE)) begin
        wrDropErr_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (swapNow) begin
            displayBank_q <= ~displayBank_q;
            state_q       <= ST_COPY;
            cnt_q         <= '0;
          end else if (cpuClearReq) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR, ST_COPY: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPRITE_RAM_READBACK_EN
  logic [31:0] cpuRdData_q;

  // CPU readback of the back bank, showing whatever an entry holds right now
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      cpuRdData_q <= '0;
    end else if (cpuRdEn) begin
      cpuRdData_q <= mem_q[backBank][cpuRdAddr];
    end
  end

  assign cpuRdData = cpuRdData_q;
`else
  // Readback port not built: the back bank is visible only after a swap.
`endif

  assign dataToEightRam = dataRd_q;
  assign cpuBusy        = (state_q != ST_IDLE) || swapPend_q;
  assign wrDropErr      = wrDropErr_q;
  assign displayBank    = displayBank_q;

endmodule

// File: doc/sprite_ram_dbuf.md
Name: sprite_ram_dbuf

Overview:
- Double-buffered 64-entry x 32-bit sprite attribute RAM. It is the responder to the per-line sprite evaluator: the evaluator issues `addrReadEightRam` and receives `dataToEightRam` one cycle later.
- The CPU-side bus writes the back bank. The banks swap on a frame boundary, so the evaluator never sees a half-updated sprite table.
- After each swap, an internal copy FSM brings the back bank up to date. A clear FSM bulk-hides all sprites.

Parameters:
- `SPRITE_NUM`, 64: entries per bank; address width is clog2(SPRITE_NUM) = 6.
- `CLEAR_WORD`, 32'h00FF0000: value written by clear and by reset. Bits[23:16] = Y = 0xFF, which keeps the sprite off every game line.

Ports:
- `clkEightRam`, in, 1: clock, shared with the evaluator.
- `rstn`, in, 1: reset, synchronous, active-low.
- `addrReadEightRam`, in, 6: evaluator read address.
- `dataToEightRam`, out, 32: registered read data from the display bank.
- `frameStart`, in, 1: one-cycle pulse at the start of vertical blanking.
- `cpuWrEn`, in, 1: write strobe to the back bank.
- `cpuWrAddr`, in, 6: write address.
- `cpuWrData`, in, 32: write data. Bits[31:24] tile, [23:16] Y, [15:8] attr, [7:0] X.
- `cpuSwapReq`, in, 1: pulse requesting a bank swap at the next `frameStart`.
- `cpuClearReq`, in, 1: pulse requesting that the back bank be filled with `CLEAR_WORD`.
- `cpuBusy`, out, 1: high while CLEAR or COPY is running, or while a swap is pending.
- `wrDropErr`, out, 1: sticky flag; set when a write arrives during CLEAR/COPY.
- `displayBank`, out, 1: index of the bank currently read by the evaluator.

Behaviour:
- Reset state:
  - Both banks = `CLEAR_WORD`; `dataToEightRam` = 0; `displayBank` = 0.
  - FSM = IDLE; `swapPend` = 0; `cpuBusy` = 0; `wrDropErr` = 0.
  - A reset asserted mid-CLEAR or mid-COPY aborts the operation and returns everything to the reset state.
- Read port:
  - Every cycle: `dataToEightRam` <= bank[`displayBank`][`addrReadEightRam`]. Latency is exactly 1 cycle and there is no enable.
  - A swap becomes visible to reads on the first cycle after `displayBank` toggles. The read registered in the toggle cycle still returns the old bank.
- Back bank = ~`displayBank`.
- CPU write:
  - In IDLE, `cpuWrEn` writes back[`cpuWrAddr`] <= `cpuWrData` in the same cycle.
  - In CLEAR or COPY, the write is discarded and `wrDropErr` is set.
- Swap request:
  - `cpuSwapReq` sets `swapPend`.
  - `frameStart` while `swapPend` = 1 and FSM = IDLE:
    - `displayBank` toggles and `swapPend` clears.
    - FSM -> COPY with counter = 0.
  - `frameStart` in the same cycle as `cpuSwapReq`: no swap this frame; the swap happens at the next `frameStart`.
  - `frameStart` while CLEAR or COPY is running: no swap; `swapPend` holds and the swap is retried at the following `frameStart`.
- FSM states IDLE, CLEAR, COPY:
  - IDLE -> CLEAR on `cpuClearReq`, with counter = 0.
  - CLEAR: each cycle back[cnt] <= `CLEAR_WORD`, cnt++. Returns to IDLE after cnt = 63 is written (64 cycles).
  - COPY: each cycle back[cnt] <= display[cnt] via a second internal combinational read, cnt++. Returns to IDLE after 64 cycles. The result is that the new back bank equals the new display bank.
  - `cpuClearReq` outside IDLE is ignored (no queueing).
- Priority in IDLE when events coincide:
  - `cpuClearReq` and `cpuSwapReq` together: CLEAR starts and the swap stays pending.
  - `cpuClearReq` and a swap-qualifying `frameStart` together: the swap wins, and the clear request is dropped.
  - `cpuWrEn` in the same IDLE cycle as a swap: the write lands in the pre-swap back bank, which is the new display bank.
- Counter: 6 bits. Termination is by explicit compare to `SPRITE_NUM`-1, so there is no wrap into a second pass.
- `cpuBusy` = (FSM != IDLE) | `swapPend`, computed combinationally from registers.

Optional Feature:
- Macro `SPRITE_RAM_READBACK_EN`.
- When defined, three extra ports are added:
  - `cpuRdEn` (in, 1)
  - `cpuRdAddr` (in, 6)
  - `cpuRdData` (out, 32), registered with 1-cycle latency, reset 0.
- `cpuRdData` returns back[`cpuRdAddr`], independent of FSM state. During CLEAR/COPY it returns whatever the entry currently holds.
- When not defined, these ports do not exist and there is no readback logic.

Test Plan:
- Reset, then read addr 0..63 -> `dataToEightRam` = 0x00FF0000 one cycle after each address; `displayBank` = 0; `cpuBusy` = 0.
- Write addr 5 = 0x12345678 in IDLE, read addr 5 -> still 0x00FF0000. Then `cpuSwapReq`, then `frameStart` -> `displayBank` = 1, `cpuBusy` high for 64 cycles of COPY, and the next read of addr 5 = 0x12345678.
- `cpuSwapReq` and `frameStart` in the same cycle -> no toggle. Second `frameStart` 100 cycles later -> toggle; `swapPend` clears.
- `cpuClearReq`, then `cpuWrEn` at cycle 10 of CLEAR -> write dropped, `wrDropErr` = 1. After 64 cycles, `cpuBusy` = 0 and all back entries = 0x00FF0000.
- Swap pending with `frameStart` during CLEAR -> no toggle. Next `frameStart` after CLEAR completes -> toggle and COPY runs.
- `rstn` low at COPY cycle 30 -> FSM IDLE, `displayBank` = 0, all entries = 0x00FF0000, `wrDropErr` = 0.
